// File: rtl/vdf_sq_loop_ctrl.sv
// rtl/vdf_sq_loop_ctrl.sv - VDF iteration controller that loops a value through an external modular squarer T times
module vdf_sq_loop_ctrl #(
    parameter  int WORD_BITS       = 8,
    parameter  int NUM_WORDS       = 4,
    parameter  int REDUN_WORD_BITS = 1,
    parameter  int ITER_BITS       = 32,
    localparam int I_WORD          = NUM_WORDS + 1,
    localparam int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_val,
    output logic                          o_rdy,
    input  logic [NUM_WORDS*WORD_BITS-1:0] i_dat,
    input  logic [ITER_BITS-1:0]          i_iter,
    output logic                          o_mul_val,
    output logic [I_WORD*COEF_BITS-1:0]   o_mul_dat,
    input  logic                          i_mul_val,
    input  logic [I_WORD*COEF_BITS-1:0]   i_mul_dat,
    output logic                          o_val,
    input  logic                          i_rdy,
    output logic [I_WORD*COEF_BITS-1:0]   o_dat,
    output logic                          o_busy,
    output logic [ITER_BITS-1:0]          o_iter_cnt,
    output logic                          o_err
);

    localparam int DAT_W = I_WORD * COEF_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DAT_W-1:0]     op_q, op_d;
    logic [DAT_W-1:0]     dat_q, dat_d;
    logic [ITER_BITS-1:0] iter_q, iter_d;
    logic [ITER_BITS-1:0] cnt_q, cnt_d;
    logic                 rdy_q, rdy_d;
    logic                 mul_val_q, mul_val_d;
    logic                 val_q, val_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    // Set when reset lands while a squaring is outstanding; swallows that one stale result.
    logic                 drain_q, drain_d;

    logic [DAT_W-1:0]     x_red;
    logic                 iter_rsvd;
    logic                 mul_hit;
    logic [ITER_BITS-1:0] cnt_inc;

    always_comb begin
        x_red = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            x_red[k*COEF_BITS +: WORD_BITS] = i_dat[k*WORD_BITS +: WORD_BITS];
        end
    end

    assign iter_rsvd = &i_iter;
    assign mul_hit   = i_mul_val && !drain_q;
    assign cnt_inc   = cnt_q + ITER_BITS'(1);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dat_d     = dat_q;
        iter_d    = iter_q;
        cnt_d     = cnt_q;
        rdy_d     = rdy_q;
        mul_val_d = 1'b0;
        val_d     = val_q;
        busy_d    = busy_q;
        err_d     = err_q;
        drain_d   = drain_q && !i_mul_val;

        if (i_val && iter_rsvd) begin
            err_d = 1'b1;
        end
        if (mul_hit && state_q != S_WAIT) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_val && rdy_q) begin
                    op_d   = x_red;
                    iter_d = iter_rsvd ? '0 : i_iter;
                    cnt_d  = '0;
                    rdy_d  = 1'b0;
                    busy_d = 1'b1;
                    if (iter_rsvd || i_iter == '0) begin
                        dat_d   = x_red;
                        val_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mul_val_d = 1'b1;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_hit) begin
                    cnt_d = cnt_inc;
                    op_d  = i_mul_dat;
                    if (cnt_inc == iter_q) begin
                        dat_d   = i_mul_dat;
                        val_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mul_val_d = 1'b1;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (i_rdy) begin
                    val_d   = 1'b0;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            dat_q     <= '0;
            iter_q    <= '0;
            cnt_q     <= '0;
            rdy_q     <= 1'b1;
            mul_val_q <= 1'b0;
            val_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            drain_q   <= (state_q == S_ISSUE) || (state_q == S_WAIT);
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dat_q     <= dat_d;
            iter_q    <= iter_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            mul_val_q <= mul_val_d;
            val_q     <= val_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            drain_q   <= drain_d;
        end
    end

    assign o_rdy      = rdy_q;
    assign o_mul_val  = mul_val_q;
    assign o_mul_dat  = op_q;
    assign o_val      = val_q;
    assign o_dat      = dat_q;
    assign o_busy     = busy_q;
    assign o_iter_cnt = cnt_q;
    assign o_err      = err_q;

endmodule

// File: doc/vdf_sq_loop_ctrl.md
Name: vdf_sq_loop_ctrl

Overview:
- Iteration controller directly upstream of the polynomial modular squarer. It accepts a binary start value and an iteration count T, and converts the value to redundant form.
- It feeds the squarer, waits for each result, and loops the result back T times. The final result is returned in redundant form on a valid/ready output.
- The squarer instance sits outside this block and connects through the o_mul_*/i_mul_* ports.

Parameters:
- WORD_BITS, 8, radix bits per coefficient.
- NUM_WORDS, 4, number of coefficients in the binary value.
- REDUN_WORD_BITS, 1, redundant bits per coefficient.
- ITER_BITS, 32, width of the iteration count.
- I_WORD, NUM_WORDS+1, redundant word count (derived; do not override).
- COEF_BITS, WORD_BITS+REDUN_WORD_BITS, coefficient width (derived; do not override).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_val  in  1  start request valid.
- o_rdy  out  1  ready for start request; high only in IDLE.
- i_dat  in  NUM_WORDS*WORD_BITS  binary start value x.
- i_iter  in  ITER_BITS  number of squarings T.
- o_mul_val  out  1  one-cycle pulse launching a squaring.
- o_mul_dat  out  I_WORD*COEF_BITS  squarer operand, redundant form.
- i_mul_val  in  1  squarer result valid.
- i_mul_dat  in  I_WORD*COEF_BITS  squarer result, redundant form.
- o_val  out  1  final result valid.
- i_rdy  in  1  downstream ready.
- o_dat  out  I_WORD*COEF_BITS  final result, redundant form.
- o_busy  out  1  high in ISSUE/WAIT/DONE.
- o_iter_cnt  out  ITER_BITS  squarings completed in the current job.
- o_err  out  1  sticky protocol error flag.

Behaviour:
- Reset values: all outputs 0, except o_rdy=1. State=IDLE, counters=0, data registers=0. Reset mid-job aborts the job immediately. A squarer result still in flight after reset is ignored and does not set o_err.
- Redundant conversion of x:
  - Word k (k<NUM_WORDS) = zero-extended i_dat[k*WORD_BITS +: WORD_BITS].
  - Word NUM_WORDS = 0.
  - Redundant bits = 0.
- States:
  - IDLE: start is accepted on i_val&&o_rdy. Latch the converted x into the operand register, latch T, clear o_iter_cnt. If T==0, go to DONE with o_dat=converted x. Otherwise go to ISSUE.
  - ISSUE (1 cycle): o_mul_val=1 and o_mul_dat=operand register. Go to WAIT.
  - WAIT: o_mul_val=0. On i_mul_val: o_iter_cnt++ and operand register <= i_mul_dat. If the new count==T, go to DONE with o_dat=i_mul_dat. Otherwise go to ISSUE.
  - DONE: o_val=1 with o_dat held stable. On i_rdy, go to IDLE; o_rdy returns high the cycle after the handshake.
- o_mul_dat holds the operand register at all times. It is only meaningful when o_mul_val=1.
- Timing, with squarer latency L (5 for the standard squarer):
  - Start handshake at edge 0.
  - First o_mul_val in cycle 1.
  - Each iteration takes L+1 cycles.
  - o_val first asserts in cycle 1+T*(L+1) for T>=1, or cycle 1 for T==0.
- Only one squaring is outstanding at a time. No pipelined interleaving.
- o_err is set, and stays set until i_rst, when:
  - i_mul_val is seen in any state other than WAIT (the result is ignored), or
  - i_val is asserted while i_iter is all-ones (reserved value; the request is accepted but treated as T=0).
- i_val while not in IDLE is not accepted (o_rdy=0). This is not an error.
- o_iter_cnt saturates at T. It stays valid in DONE and clears on the next accepted start.
- A same-cycle i_rdy and new i_val is not possible, because o_rdy=0 in DONE.

Test Plan:
- Squarer model with L=5, MODULUS=128, x=3, T=2 -> o_mul_val pulses in cycles 1 and 7. o_val rises in cycle 13. o_dat reduces to 81 (3^4 mod 128), with words [81,0,0,0,0]. o_iter_cnt=2.
- x=0x12345678, T=0 -> no o_mul_val pulse. o_val in cycle 1. o_dat words=[0x78,0x56,0x34,0x12,0]. o_iter_cnt=0.
- Backpressure: T=1, i_rdy held 0 for 10 cycles after o_val -> o_dat and o_val remain stable. o_rdy stays 0. After i_rdy=1, o_rdy=1 on the next cycle.
- Stray i_mul_val in IDLE -> o_err=1 and o_iter_cnt unchanged. o_err stays 1 across a subsequent job, and clears only on i_rst.
- Reset asserted in WAIT (T=5, after 2 iterations) -> next cycle all outputs at reset values. The late i_mul_val is ignored with o_err=0. A new job x=5, T=1 gives o_dat=25.
- Back-to-back jobs (x=2,T=3 then x=7,T=1 with i_rdy=1) -> results 256 mod 128=0, then 49. The second start is accepted in the cycle after the first DONE handshake.
